// File: rtl/uart_sched_pkg.sv
// Shared definitions for the uart_tx byte scheduler.
// State encoding, default timing parameters and requester indices.
package uart_sched_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SEND = ST_SEND,
    S_WAIT = ST_WAIT,
    S_GAP  = ST_GAP,
    S_HOLD = ST_HOLD
  } state_t;

  localparam int GAP_CLKS_DEF     = 0;
  localparam int TIMEOUT_CLKS_DEF = 2048;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic owner_idx(
    input logic [1:0] grant
  );
    return grant[1] ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Combinational 2-way round-robin pick.
// i_Valid: requests; i_Last_Grant: previous owner; o_Grant: one-hot.
module uart_rr_arb2
  import uart_sched_pkg::*;
(
  input  logic [1:0] i_Valid,
  input  logic       i_Last_Grant,
  output logic [1:0] o_Grant
);

  always_comb begin
    o_Grant = 2'b00;
    unique case (i_Valid)
      2'b01:   o_Grant = 2'b01;
      2'b10:   o_Grant = 2'b10;
      2'b11:   o_Grant = (i_Last_Grant == REQ1) ? 2'b01 : 2'b10;
      default: o_Grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between two byte requesters with packet lock.
// Req0/Req1 valid/ready byte ports in; Tx_DV/Tx_Byte to uart_tx out.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int GAP_CLKS     = GAP_CLKS_DEF,
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Req0_Valid,
  input  logic [7:0] i_Req0_Byte,
  input  logic       i_Req0_Last,
  output logic       o_Req0_Ready,
  input  logic       i_Req1_Valid,
  input  logic [7:0] i_Req1_Byte,
  input  logic       i_Req1_Last,
  output logic       o_Req1_Ready,
  output logic       o_Tx_DV,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Active,
  input  logic       i_Tx_Done,
  output logic [1:0] o_Grant,
  output logic       o_Busy,
  output logic       o_Timeout
);

  localparam int WW = $clog2(TIMEOUT_CLKS);
  localparam int GW =
    (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [WW-1:0] WD_LAST =
    WW'(TIMEOUT_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  state_t        r_State, w_State;
  logic [1:0]    r_Grant, w_Grant;
  logic          r_Last, w_Last;
  logic          r_Last_Grant, w_Last_Grant;
  logic          r_Tx_DV, w_Tx_DV;
  logic [7:0]    r_Tx_Byte, w_Tx_Byte;
  logic          r_Timeout, w_Timeout;
  logic [WW-1:0] r_Wdog, w_Wdog;
  logic [GW-1:0] r_Gap, w_Gap;

  logic [1:0] w_Pick;
  logic       w_Hs;
  logic [7:0] w_Sel_Byte;
  logic       w_Sel_Last;
  logic       w_Own_Valid;

  uart_rr_arb2 u_arb (
    .i_Valid      ({i_Req1_Valid, i_Req0_Valid}),
    .i_Last_Grant (r_Last_Grant),
    .o_Grant      (w_Pick)
  );

  assign o_Req0_Ready =
    (r_State == S_SEND) & r_Grant[0] & ~i_Tx_Active;
  assign o_Req1_Ready =
    (r_State == S_SEND) & r_Grant[1] & ~i_Tx_Active;

  assign w_Hs =
    (o_Req0_Ready & i_Req0_Valid) |
    (o_Req1_Ready & i_Req1_Valid);

  assign w_Sel_Byte =
    r_Grant[1] ? i_Req1_Byte : i_Req0_Byte;
  assign w_Sel_Last =
    r_Grant[1] ? i_Req1_Last : i_Req0_Last;
  assign w_Own_Valid =
    r_Grant[1] ? i_Req1_Valid : i_Req0_Valid;

  always_comb begin
    w_State      = r_State;
    w_Grant      = r_Grant;
    w_Last       = r_Last;
    w_Last_Grant = r_Last_Grant;
    w_Tx_DV      = 1'b0;
    w_Tx_Byte    = r_Tx_Byte;
    w_Timeout    = 1'b0;
    w_Wdog       = r_Wdog;
    w_Gap        = r_Gap;
    unique case (r_State)
      S_IDLE: begin
        if (|w_Pick) begin
          w_Grant = w_Pick;
          w_State = S_SEND;
        end
      end
      S_SEND: begin
        if (w_Hs) begin
          w_Tx_Byte = w_Sel_Byte;
          w_Last    = w_Sel_Last;
          w_Tx_DV   = 1'b1;
          w_Wdog    = '0;
          w_State   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done is checked first so it wins over expiry.
        if (i_Tx_Done) begin
          if (r_Last) begin
            w_Grant      = 2'b00;
            w_Last_Grant = owner_idx(r_Grant);
          end
          if (GAP_CLKS == 0) begin
            w_State = r_Last ? S_IDLE : S_HOLD;
          end else begin
            w_Gap   = '0;
            w_State = S_GAP;
          end
        end else if (r_Wdog == WD_LAST) begin
          w_Timeout    = 1'b1;
          w_Grant      = 2'b00;
          w_Last       = 1'b0;
          w_Last_Grant = owner_idx(r_Grant);
          w_State      = S_IDLE;
        end else begin
          w_Wdog = r_Wdog + WW'(1);
        end
      end
      S_GAP: begin
        if (r_Gap == GAP_LAST) begin
          w_State = (|r_Grant) ? S_HOLD : S_IDLE;
        end else begin
          w_Gap = r_Gap + GW'(1);
        end
      end
      S_HOLD: begin
        if (w_Own_Valid) begin
          w_State = S_SEND;
        end
      end
      default: w_State = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State      <= S_IDLE;
      r_Grant      <= 2'b00;
      r_Last       <= 1'b0;
      r_Last_Grant <= REQ1;
      r_Tx_DV      <= 1'b0;
      r_Tx_Byte    <= 8'h00;
      r_Timeout    <= 1'b0;
      r_Wdog       <= '0;
      r_Gap        <= '0;
    end else begin
      r_State      <= w_State;
      r_Grant      <= w_Grant;
      r_Last       <= w_Last;
      r_Last_Grant <= w_Last_Grant;
      r_Tx_DV      <= w_Tx_DV;
      r_Tx_Byte    <= w_Tx_Byte;
      r_Timeout    <= w_Timeout;
      r_Wdog       <= w_Wdog;
      r_Gap        <= w_Gap;
    end
  end

  assign o_Tx_DV   = r_Tx_DV;
  assign o_Tx_Byte = r_Tx_Byte;
  assign o_Grant   = r_Grant;
  assign o_Timeout = r_Timeout;
  assign o_Busy    = (r_State != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler with behavioural uart_tx models.
// Instance a: GAP_CLKS=0, TIMEOUT_CLKS=64; instance b: GAP_CLKS=5.
module tb_uart_tx_scheduler;

  localparam int FRAME = 40;
  localparam int LIMIT = 3000;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v0 = 0, l0 = 0, v1 = 0, l1 = 0;
  logic [7:0] b0 = 0, b1 = 0;
  logic       r0, r1, dv, busy, tmo;
  logic [7:0] txb;
  logic [1:0] grant;
  logic       act, done;
  logic       suppress = 0;
  int         acnt;

  logic       bv0 = 0, bl0 = 0, bv1 = 0, bl1 = 0;
  logic [7:0] bb0 = 0, bb1 = 0;
  logic       br0, br1, bdv, bbusy, btmo;
  logic [7:0] btxb;
  logic [1:0] bgrant;
  logic       bact, bdone;
  int         bcnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_tx_scheduler #(
    .GAP_CLKS(0), .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Req0_Valid(v0), .i_Req0_Byte(b0),
    .i_Req0_Last(l0), .o_Req0_Ready(r0),
    .i_Req1_Valid(v1), .i_Req1_Byte(b1),
    .i_Req1_Last(l1), .o_Req1_Ready(r1),
    .o_Tx_DV(dv), .o_Tx_Byte(txb),
    .i_Tx_Active(act), .i_Tx_Done(done),
    .o_Grant(grant), .o_Busy(busy),
    .o_Timeout(tmo)
  );

  uart_tx_scheduler #(
    .GAP_CLKS(5), .TIMEOUT_CLKS(TMO)
  ) dut_b (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Req0_Valid(bv0), .i_Req0_Byte(bb0),
    .i_Req0_Last(bl0), .o_Req0_Ready(br0),
    .i_Req1_Valid(bv1), .i_Req1_Byte(bb1),
    .i_Req1_Last(bl1), .o_Req1_Ready(br1),
    .o_Tx_DV(bdv), .o_Tx_Byte(btxb),
    .i_Tx_Active(bact), .i_Tx_Done(bdone),
    .o_Grant(bgrant), .o_Busy(bbusy),
    .o_Timeout(btmo)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= 0; done <= 0; acnt <= 0;
    end else begin
      done <= 0;
      if (dv && !act) begin
        act <= 1; acnt <= FRAME - 1;
      end else if (act) begin
        if (acnt == 0) begin
          act <= 0; done <= !suppress;
        end else acnt <= acnt - 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bact <= 0; bdone <= 0; bcnt <= 0;
    end else begin
      bdone <= 0;
      if (bdv && !bact) begin
        bact <= 1; bcnt <= FRAME - 1;
      end else if (bact) begin
        if (bcnt == 0) begin
          bact <= 0; bdone <= 1;
        end else bcnt <= bcnt - 1;
      end
    end
  end

  logic [7:0] obs_a[256];
  int         obs_a_cyc[256];
  int         obs_a_n = 0;
  logic [7:0] obs_b[256];
  int         obs_b_cyc[256];
  int         obs_b_n = 0;
  int         doneb_cyc[16];
  int         doneb_n = 0;
  int         viol = 0;
  int         rd_a = 0;
  int         rd_b = 0;

  always @(negedge clk) begin
    if (dv) begin
      obs_a[obs_a_n[7:0]] <= txb;
      obs_a_cyc[obs_a_n[7:0]] <= cyc;
      obs_a_n <= obs_a_n + 1;
    end
    if (bdv) begin
      obs_b[obs_b_n[7:0]] <= btxb;
      obs_b_cyc[obs_b_n[7:0]] <= cyc;
      obs_b_n <= obs_b_n + 1;
    end
    if (bdone) begin
      doneb_cyc[doneb_n[3:0]] <= cyc;
      doneb_n <= doneb_n + 1;
    end
    if ((dv && (act || done)) ||
        (bdv && (bact || bdone)))
      viol <= viol + 1;
  end

  logic [7:0] exp_q[$];

  task automatic get_obs_a(
    output logic [7:0] b, output int c,
    output bit ok
  );
    int n = 0;
    while (obs_a_n <= rd_a && n < LIMIT) begin
      @(negedge clk); n++;
    end
    ok = (obs_a_n > rd_a);
    b = ok ? obs_a[rd_a[7:0]] : 8'hxx;
    c = ok ? obs_a_cyc[rd_a[7:0]] : -1;
    if (ok) rd_a++;
  endtask

  task automatic get_obs_b(
    output logic [7:0] b, output int c,
    output bit ok
  );
    int n = 0;
    while (obs_b_n <= rd_b && n < LIMIT) begin
      @(negedge clk); n++;
    end
    ok = (obs_b_n > rd_b);
    b = ok ? obs_b[rd_b[7:0]] : 8'hxx;
    c = ok ? obs_b_cyc[rd_b[7:0]] : -1;
    if (ok) rd_b++;
  endtask

  task automatic drive0(
    input logic [7:0] b, input logic l
  );
    int n = 0;
    v0 = 1; b0 = b; l0 = l;
    @(negedge clk);
    while (!r0 && n < LIMIT) begin
      @(negedge clk); n++;
    end
    if (!r0) begin
      checks++; errors++;
      $display("FAIL drive0: no ready, byte 0x%02h", b);
    end
    @(posedge clk); #1 v0 = 0;
  endtask

  task automatic drive1(
    input logic [7:0] b, input logic l
  );
    int n = 0;
    v1 = 1; b1 = b; l1 = l;
    @(negedge clk);
    while (!r1 && n < LIMIT) begin
      @(negedge clk); n++;
    end
    if (!r1) begin
      checks++; errors++;
      $display("FAIL drive1: no ready, byte 0x%02h", b);
    end
    @(posedge clk); #1 v1 = 0;
  endtask

  task automatic driveb(
    input logic [7:0] b, input logic l
  );
    int n = 0;
    bv0 = 1; bb0 = b; bl0 = l;
    @(negedge clk);
    while (!br0 && n < LIMIT) begin
      @(negedge clk); n++;
    end
    if (!br0) begin
      checks++; errors++;
      $display("FAIL driveb: no ready, byte 0x%02h", b);
    end
    @(posedge clk); #1 bv0 = 0;
  endtask

  task automatic wait_idle(input bit on_b);
    int n = 0;
    while (n < LIMIT &&
           (on_b ? (bbusy || bact) : (busy || act))) begin
      @(negedge clk); n++;
    end
    if (on_b ? (bbusy || bact) : (busy || act)) begin
      checks++; errors++;
      $display("FAIL wait_idle: still busy, b=%0d", on_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checks += 7;
    if (dv !== 1'b0) begin errors++;
      $display("FAIL reset_dv: got %b want 0", dv); end
    if (txb !== 8'h00) begin errors++;
      $display("FAIL reset_byte: got %h want 00", txb); end
    if (grant !== 2'b00) begin errors++;
      $display("FAIL reset_grant: got %b want 00", grant); end
    if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    if (tmo !== 1'b0) begin errors++;
      $display("FAIL reset_tmo: got %b want 0", tmo); end
    if (r0 !== 1'b0) begin errors++;
      $display("FAIL reset_r0: got %b want 0", r0); end
    if (r1 !== 1'b0) begin errors++;
      $display("FAIL reset_r1: got %b want 0", r1); end
  endtask

  task automatic test_tie();
    logic [7:0] g, e;
    int c;
    bit ok;
    exp_q = '{8'h11, 8'h22, 8'h11, 8'h22};
    @(posedge clk); #1;
    fork drive0(8'h11, 1); drive1(8'h22, 1); join
    fork drive0(8'h11, 1); drive1(8'h22, 1); join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs_a(g, c, ok);
      checks++;
      if (!ok || g !== e) begin errors++;
        $display("FAIL tie_order: got %h ok=%0d want %h",
                 g, ok, e); end
    end
    wait_idle(0);
  endtask

  task automatic test_single();
    logic [7:0] g;
    int c, n;
    bit ok;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    v0 = 1; b0 = 8'hA5; l0 = 1;
    @(negedge clk);
    checks++;
    if (r0 !== 1'b0) begin errors++;
      $display("FAIL single_c0_ready: got %b want 0", r0); end
    @(negedge clk);
    checks++;
    if (r0 !== 1'b1) begin errors++;
      $display("FAIL single_c1_ready: got %b want 1", r0); end
    @(posedge clk); #1 v0 = 0;
    @(negedge clk);
    checks++;
    if (dv !== 1'b1 || txb !== 8'hA5) begin errors++;
      $display("FAIL single_c2_dv: got dv=%b %h want 1 a5",
               dv, txb); end
    @(negedge clk);
    checks++;
    if (dv !== 1'b0) begin errors++;
      $display("FAIL single_c3_dv: got %b want 0", dv); end
    get_obs_a(g, c, ok);
    checks++;
    if (!ok || g !== exp_q.pop_front()) begin errors++;
      $display("FAIL single_sb: got %h ok=%0d want a5",
               g, ok); end
    n = 0;
    while (!done && n < LIMIT) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin errors++;
      $display("FAIL single_end: got g=%b busy=%b want 00 0",
               grant, busy); end
    repeat (5) @(negedge clk);
    checks++;
    if (obs_a_n != rd_a) begin errors++;
      $display("FAIL single_extra_dv: got %0d want 0",
               obs_a_n - rd_a); end
  endtask

  task automatic test_lock();
    logic [7:0] g, e;
    int c;
    bit ok;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h55};
    @(posedge clk); #1;
    fork
      begin
        drive0(8'h01, 0);
        drive0(8'h02, 0);
        drive0(8'h03, 1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 drive1(8'h55, 1);
      end
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs_a(g, c, ok);
      checks++;
      if (!ok || g !== e) begin errors++;
        $display("FAIL lock_order: got %h ok=%0d want %h",
                 g, ok, e); end
    end
    wait_idle(0);
    checks++;
    if (viol != 0) begin errors++;
      $display("FAIL dv_overlap: got %0d want 0", viol); end
  endtask

  task automatic test_hold();
    logic [7:0] g, e;
    int c, hits;
    bit ok;
    hits = 0;
    exp_q = '{8'h10, 8'h20, 8'h77};
    @(posedge clk); #1;
    fork
      begin
        drive0(8'h10, 0);
        repeat (500) begin
          @(negedge clk);
          if (r1) hits++;
        end
        @(posedge clk); #1;
        drive0(8'h20, 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 drive1(8'h77, 1);
      end
    join
    checks++;
    if (hits != 0) begin errors++;
      $display("FAIL hold_ready1: got %0d want 0", hits); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_obs_a(g, c, ok);
      checks++;
      if (!ok || g !== e) begin errors++;
        $display("FAIL hold_order: got %h ok=%0d want %h",
                 g, ok, e); end
    end
    wait_idle(0);
  endtask

  task automatic test_gap();
    logic [7:0] g, e;
    int c;
    bit ok;
    exp_q = '{8'h3C, 8'hC3};
    @(posedge clk); #1;
    driveb(8'h3C, 0);
    driveb(8'hC3, 1);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      get_obs_b(g, c, ok);
      checks++;
      if (!ok || g !== e) begin errors++;
        $display("FAIL gap_byte: got %h ok=%0d want %h",
                 g, ok, e); end
      if (i == 1) begin
        checks++;
        if (!ok || doneb_n < 1 ||
            c - doneb_cyc[0] != 8) begin errors++;
          $display("FAIL gap_latency: got %0d want 8",
                   c - doneb_cyc[0]); end
      end
    end
    wait_idle(1);
  endtask

  task automatic test_timeout();
    logic [7:0] g;
    int c, n, tc;
    bit ok;
    suppress = 1;
    @(posedge clk); #1;
    drive0(8'h99, 1);
    get_obs_a(g, c, ok);
    checks++;
    if (!ok || g !== 8'h99) begin errors++;
      $display("FAIL tmo_byte: got %h want 99", g); end
    n = 0;
    while (!tmo && n < LIMIT) begin
      @(negedge clk); n++;
    end
    tc = cyc;
    checks += 3;
    if (!tmo || tc - c != TMO) begin errors++;
      $display("FAIL tmo_delay: got %0d want %0d",
               tc - c, TMO); end
    if (busy !== 1'b0) begin errors++;
      $display("FAIL tmo_busy: got %b want 0", busy); end
    if (grant !== 2'b00) begin errors++;
      $display("FAIL tmo_grant: got %b want 00", grant); end
    @(negedge clk);
    checks++;
    if (tmo !== 1'b0) begin errors++;
      $display("FAIL tmo_width: got %b want 0", tmo); end
    suppress = 0;
    wait_idle(0);
  endtask

  task automatic test_reset_wait();
    logic [7:0] g;
    int c, base;
    bit ok;
    @(posedge clk); #1;
    drive0(8'h5A, 1);
    get_obs_a(g, c, ok);
    checks++;
    if (!ok || g !== 8'h5A) begin errors++;
      $display("FAIL rstw_byte: got %h want 5a", g); end
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if (dv !== 0 || txb !== 8'h00 || grant !== 2'b00 ||
        busy !== 0 || tmo !== 0 || r0 !== 0 ||
        r1 !== 0) begin errors++;
      $display("FAIL rstw_async: got dv=%b b=%h g=%b bz=%b",
               dv, txb, grant, busy);
    end
    @(posedge clk); #1 rst_n = 1;
    base = obs_a_n;
    repeat (60) @(negedge clk);
    checks++;
    if (obs_a_n != base) begin errors++;
      $display("FAIL rstw_no_dv: got %0d want 0",
               obs_a_n - base); end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation stuck");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_lock();
    test_hold();
    test_gap();
    test_timeout();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
